issue_bank_mp: RTL and testbench

- Multi-port, age-ordered reservation-station bank for the backend issue stage, sitting between rename/dispatch and the functional-unit pipes.
- Generalises the single-enqueue, single-select bank in three ways: ENQ_NUM entries per cycle, DEQ_NUM oldest-ready issues per cycle, and a parametrised source-operand count.
- Adds same-cycle wakeup bypass at enqueue and strict oldest-first selection through an age matrix.
- Flushes entries younger than a backend redirect.

---
 rtl/issue_bank_mp.sv | 183 ++++++++++++++++++
 tb/tb_issue_bank_mp.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_bank_mp.sv
// rtl/issue_bank_mp.sv - multi-port age-ordered reservation-station bank
// Oldest-first selection through an age matrix, wakeup bypass at enqueue, redirect flush.
module issue_bank_mp #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 64,
  parameter int ENQ_NUM    = 2,
  parameter int DEQ_NUM    = 2,
  parameter int SRC_NUM    = 2,
  parameter int WB_SIZE    = 4,
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ENQ_NUM-1:0]                    enq_valid,
  output logic                                  enq_ready,
  input  logic [ENQ_NUM*SRC_NUM*PREG_WIDTH-1:0] enq_src,
  input  logic [ENQ_NUM*SRC_NUM-1:0]            enq_src_rdy,
  input  logic [ENQ_NUM*(ROB_WIDTH+1)-1:0]      enq_rob,
  input  logic [ENQ_NUM*DATA_WIDTH-1:0]         enq_data,
  input  logic [WB_SIZE-1:0]                    wb_en,
  input  logic [WB_SIZE*PREG_WIDTH-1:0]         wb_rd,
  output logic [DEQ_NUM-1:0]                    iss_valid,
  input  logic [DEQ_NUM-1:0]                    iss_ready,
  output logic [DEQ_NUM*DATA_WIDTH-1:0]         iss_data,
  output logic [DEQ_NUM*(ROB_WIDTH+1)-1:0]      iss_rob,
  output logic [DEQ_NUM*SRC_NUM*PREG_WIDTH-1:0] iss_src,
  input  logic                                  redirect,
  input  logic [ROB_WIDTH:0]                    redirect_rob,
  output logic [$clog2(DEPTH+1)-1:0]            count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int RW = ROB_WIDTH + 1;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [SRC_NUM-1:0]    rdy_q [DEPTH];
  logic [SRC_NUM-1:0]    rdy_d [DEPTH];
  logic [DEPTH-1:0]      old_q [DEPTH];
  logic [DEPTH-1:0]      old_d [DEPTH];
  logic [PREG_WIDTH-1:0] src_q [DEPTH][SRC_NUM];
  logic [RW-1:0]         rob_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [CW-1:0]         count_q, count_d;

  logic [DEPTH-1:0]      ready;
  logic [DEPTH-1:0]      cand;
  logic                  oldest;
  logic [DEQ_NUM-1:0]    sel_found;
  logic [IW-1:0]         sel_idx [DEQ_NUM];
  logic [DEPTH-1:0]      avail;
  logic                  alloc_hit;
  logic [ENQ_NUM-1:0]    enq_fire;
  logic [IW-1:0]         alloc_idx [ENQ_NUM];

  function automatic logic woken(input logic [PREG_WIDTH-1:0] p);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < WB_SIZE; j++)
      if (wb_en[j] && wb_rd[j*PREG_WIDTH +: PREG_WIDTH] == p) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic younger(input logic [RW-1:0] a, input logic [RW-1:0] r);
    if (a[RW-1] == r[RW-1]) return a[RW-2:0] > r[RW-2:0];
    else                    return a[RW-2:0] < r[RW-2:0];
  endfunction

  assign enq_ready = (int'(count_q) <= DEPTH - ENQ_NUM);
  assign count     = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ready[i] = valid_q[i] & (&rdy_q[i]);
  end

  // Each slot takes the oldest candidate left after earlier slots removed theirs.
  always_comb begin
    cand   = ready;
    oldest = 1'b0;
    for (int k = 0; k < DEQ_NUM; k++) begin
      sel_found[k] = 1'b0;
      sel_idx[k]   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        oldest = cand[i];
        for (int j = 0; j < DEPTH; j++)
          if (cand[j] && old_q[j][i]) oldest = 1'b0;
        if (oldest && !sel_found[k]) begin
          sel_found[k] = 1'b1;
          sel_idx[k]   = IW'(i);
        end
      end
      if (sel_found[k]) cand[sel_idx[k]] = 1'b0;
    end
  end

  // Allocation sees only entries free at the start of the cycle.
  always_comb begin
    avail     = ~valid_q;
    alloc_hit = 1'b0;
    for (int p = 0; p < ENQ_NUM; p++) begin
      alloc_idx[p] = '0;
      alloc_hit    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (avail[i] && !alloc_hit) begin
          alloc_hit    = 1'b1;
          alloc_idx[p] = IW'(i);
        end
      end
      enq_fire[p] = enq_valid[p] & enq_ready & ~redirect & alloc_hit;
      if (enq_fire[p]) avail[alloc_idx[p]] = 1'b0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      old_d[i] = old_q[i];
      rdy_d[i] = rdy_q[i];
      for (int s = 0; s < SRC_NUM; s++)
        if (woken(src_q[i][s])) rdy_d[i][s] = 1'b1;
    end
    if (redirect) begin
      for (int i = 0; i < DEPTH; i++)
        if (valid_q[i] && younger(rob_q[i], redirect_rob)) valid_d[i] = 1'b0;
    end else begin
      for (int k = 0; k < DEQ_NUM; k++)
        if (iss_valid[k] && iss_ready[k]) valid_d[sel_idx[k]] = 1'b0;
      for (int p = 0; p < ENQ_NUM; p++) begin
        if (enq_fire[p]) begin
          valid_d[alloc_idx[p]] = 1'b1;
          for (int s = 0; s < SRC_NUM; s++)
            rdy_d[alloc_idx[p]][s] = enq_src_rdy[p*SRC_NUM+s] |
                                     woken(enq_src[(p*SRC_NUM+s)*PREG_WIDTH +: PREG_WIDTH]);
          old_d[alloc_idx[p]] = '0;
          for (int j = 0; j < DEPTH; j++) old_d[j][alloc_idx[p]] = valid_q[j];
          for (int q = 0; q < p; q++)
            if (enq_fire[q]) old_d[alloc_idx[q]][alloc_idx[p]] = 1'b1;
        end
      end
    end
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(valid_d[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdy_q[i] <= '0;
        old_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        rdy_q[i] <= rdy_d[i];
        old_q[i] <= old_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < ENQ_NUM; p++) begin
      if (enq_fire[p]) begin
        data_q[alloc_idx[p]] <= enq_data[p*DATA_WIDTH +: DATA_WIDTH];
        rob_q[alloc_idx[p]]  <= enq_rob[p*RW +: RW];
        for (int s = 0; s < SRC_NUM; s++)
          src_q[alloc_idx[p]][s] <= enq_src[(p*SRC_NUM+s)*PREG_WIDTH +: PREG_WIDTH];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DEQ_NUM; k++) begin
      iss_valid[k]                         = sel_found[k] & ~redirect;
      iss_data[k*DATA_WIDTH +: DATA_WIDTH] = data_q[sel_idx[k]];
      iss_rob[k*RW +: RW]                  = rob_q[sel_idx[k]];
      for (int s = 0; s < SRC_NUM; s++)
        iss_src[(k*SRC_NUM+s)*PREG_WIDTH +: PREG_WIDTH] = src_q[sel_idx[k]][s];
    end
  end
endmodule

// File: tb/tb_issue_bank_mp.sv
// tb/tb_issue_bank_mp.sv - self-checking bench for issue_bank_mp
// Directed scenarios plus a randomized run against an age-ordered queue model.
module tb_issue_bank_mp;
  logic         clk, rst;
  logic [1:0]   enq_valid;
  logic         enq_ready;
  logic [27:0]  enq_src;
  logic [3:0]   enq_src_rdy;
  logic [13:0]  enq_rob;
  logic [127:0] enq_data;
  logic [3:0]   wb_en;
  logic [27:0]  wb_rd;
  logic [1:0]   iss_valid, iss_ready;
  logic [127:0] iss_data;
  logic [13:0]  iss_rob;
  logic [27:0]  iss_src;
  logic         redirect;
  logic [6:0]   redirect_rob;
  logic [4:0]   count;

  issue_bank_mp dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_src(enq_src), .enq_src_rdy(enq_src_rdy), .enq_rob(enq_rob),
    .enq_data(enq_data), .wb_en(wb_en), .wb_rd(wb_rd), .iss_valid(iss_valid),
    .iss_ready(iss_ready), .iss_data(iss_data), .iss_rob(iss_rob),
    .iss_src(iss_src), .redirect(redirect), .redirect_rob(redirect_rob),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]      rob;
    logic [63:0]     data;
    logic [1:0][6:0] src;
    logic [1:0]      rdy;
  } ent_t;

  ent_t        m_q[$];
  logic [1:0]  exp_valid;
  int          exp_pos [2];
  logic [6:0]  exp_rob [2];
  logic [63:0] exp_data [2];
  logic [13:0] exp_src [2];
  logic [63:0] last_data [2];
  int          errors = 0;
  int          checks = 0;

  function automatic logic wb_hit(input logic [6:0] p);
    for (int j = 0; j < 4; j++)
      if (wb_en[j] && wb_rd[j*7 +: 7] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic is_younger(input logic [6:0] a, input logic [6:0] r);
    int ai, ri;
    ai = int'(a[5:0]);
    ri = int'(r[5:0]);
    return (a[6] == r[6]) ? (ai > ri) : (ai < ri);
  endfunction

  function automatic void model_expect();
    int n;
    n = 0;
    exp_valid = 2'b00;
    for (int k = 0; k < 2; k++) begin
      exp_pos[k] = 0; exp_rob[k] = '0; exp_data[k] = '0; exp_src[k] = '0;
    end
    for (int i = 0; i < m_q.size(); i++) begin
      if (m_q[i].rdy == 2'b11 && n < 2) begin
        exp_valid[n] = 1'b1;
        exp_pos[n]   = i;
        exp_rob[n]   = m_q[i].rob;
        exp_data[n]  = m_q[i].data;
        exp_src[n]   = m_q[i].src;
        n++;
      end
    end
    if (redirect) exp_valid = 2'b00;
  endfunction

  task automatic clear_inputs();
    enq_valid = '0; enq_src = '0; enq_src_rdy = '0; enq_rob = '0; enq_data = '0;
    wb_en = '0; wb_rd = '0; redirect = 1'b0; redirect_rob = '0;
  endtask

  task automatic set_enq(input int p, input logic [6:0] rob, input logic [6:0] s0,
                         input logic [6:0] s1, input logic [1:0] r);
    enq_valid[p]             = 1'b1;
    enq_rob[p*7 +: 7]        = rob;
    last_data[p]             = {$urandom, $urandom};
    enq_data[p*64 +: 64]     = last_data[p];
    enq_src[(p*2)*7 +: 7]    = s0;
    enq_src[(p*2+1)*7 +: 7]  = s1;
    enq_src_rdy[p*2 +: 2]    = r;
  endtask

  task automatic peek();
    #1;
    model_expect();
  endtask

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic step();
    int   sz0;
    ent_t e;
    model_expect();
    @(posedge clk);
    sz0 = m_q.size();
    if (redirect) begin
      for (int i = m_q.size() - 1; i >= 0; i--)
        if (is_younger(m_q[i].rob, redirect_rob)) m_q.delete(i);
    end else begin
      if (exp_valid[1] && iss_ready[1]) m_q.delete(exp_pos[1]);
      if (exp_valid[0] && iss_ready[0]) m_q.delete(exp_pos[0]);
    end
    for (int i = 0; i < m_q.size(); i++)
      for (int s = 0; s < 2; s++)
        if (wb_hit(m_q[i].src[s])) m_q[i].rdy[s] = 1'b1;
    if (!redirect && sz0 <= 14) begin
      for (int p = 0; p < 2; p++) begin
        if (enq_valid[p]) begin
          e.rob  = enq_rob[p*7 +: 7];
          e.data = enq_data[p*64 +: 64];
          for (int s = 0; s < 2; s++) begin
            e.src[s] = enq_src[(p*2+s)*7 +: 7];
            e.rdy[s] = enq_src_rdy[p*2+s] | wb_hit(e.src[s]);
          end
          m_q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    iss_ready = 2'b00;
    rst = 1'b1;
    m_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    peek();
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL reset_iss_valid got=%b exp=00", iss_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
  endtask

  task automatic test_basic();
    logic [63:0] d0, d1;
    do_reset();
    set_enq(0, 7'd3, 7'd1, 7'd2, 2'b11);
    set_enq(1, 7'd4, 7'd3, 7'd4, 2'b11);
    d0 = last_data[0]; d1 = last_data[1];
    peek();
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL basic_same_cycle got=%b exp=00", iss_valid); end
    step();
    clear_inputs();
    peek();
    checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got=%b exp=11", iss_valid); end
    checks++; if (iss_rob[6:0] !== 7'd3) begin errors++; $display("FAIL basic_rob0 got=%0d exp=3", iss_rob[6:0]); end
    checks++; if (iss_rob[13:7] !== 7'd4) begin errors++; $display("FAIL basic_rob1 got=%0d exp=4", iss_rob[13:7]); end
    checks++; if (iss_data[63:0] !== d0) begin errors++; $display("FAIL basic_data0 got=%h exp=%h", iss_data[63:0], d0); end
    checks++; if (iss_data[127:64] !== d1) begin errors++; $display("FAIL basic_data1 got=%h exp=%h", iss_data[127:64], d1); end
    checks++; if (iss_src[13:0] !== {7'd2, 7'd1}) begin errors++; $display("FAIL basic_src0 got=%h exp=%h", iss_src[13:0], {7'd2, 7'd1}); end
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL basic_count2 got=%0d exp=2", count); end
    iss_ready = 2'b11;
    step();
    peek();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL basic_count0 got=%0d exp=0", count); end
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL basic_empty got=%b exp=00", iss_valid); end
  endtask

  task automatic test_fill();
    do_reset();
    iss_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      set_enq(0, 7'(2*c), 7'd100, 7'd101, 2'b00);
      set_enq(1, 7'(2*c+1), 7'd100, 7'd101, 2'b00);
      peek();
      checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL fill_enq_ready c=%0d got=%b exp=1", c, enq_ready); end
      step();
    end
    peek();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", count); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", enq_ready); end
    set_enq(0, 7'd40, 7'd1, 7'd1, 2'b11);
    set_enq(1, 7'd41, 7'd1, 7'd1, 2'b11);
    step();
    clear_inputs();
    peek();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_overflow_count got=%0d exp=16", count); end
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL fill_no_issue got=%b exp=00", iss_valid); end
  endtask

  task automatic test_wakeup();
    do_reset();
    iss_ready = 2'b11;
    set_enq(0, 7'd5, 7'd20, 7'd1, 2'b10);
    step();
    clear_inputs();
    peek();
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL wake_before got=%b exp=00", iss_valid); end
    wb_en = 4'b0100;
    wb_rd[14 +: 7] = 7'd20;
    set_enq(0, 7'd6, 7'd20, 7'd2, 2'b10);
    peek();
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL wake_same_cycle got=%b exp=00", iss_valid); end
    step();
    clear_inputs();
    peek();
    checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL wake_valid got=%b exp=11", iss_valid); end
    checks++; if (iss_rob[6:0] !== 7'd5) begin errors++; $display("FAIL wake_rob0 got=%0d exp=5", iss_rob[6:0]); end
    checks++; if (iss_rob[13:7] !== 7'd6) begin errors++; $display("FAIL wake_bypass_rob1 got=%0d exp=6", iss_rob[13:7]); end
    step();
  endtask

  task automatic test_age();
    do_reset();
    iss_ready = 2'b00;
    set_enq(0, 7'd9, 7'd1, 7'd1, 2'b11); step(); clear_inputs();
    set_enq(0, 7'd7, 7'd1, 7'd1, 2'b11); step(); clear_inputs();
    set_enq(0, 7'd8, 7'd1, 7'd1, 2'b11); step(); clear_inputs();
    peek();
    checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL age_valid got=%b exp=11", iss_valid); end
    checks++; if (iss_rob[6:0] !== 7'd9) begin errors++; $display("FAIL age_rob0 got=%0d exp=9", iss_rob[6:0]); end
    checks++; if (iss_rob[13:7] !== 7'd7) begin errors++; $display("FAIL age_rob1 got=%0d exp=7", iss_rob[13:7]); end
    iss_ready = 2'b11;
    step();
    peek();
    checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL age_next_valid got=%b exp=01", iss_valid); end
    checks++; if (iss_rob[6:0] !== 7'd8) begin errors++; $display("FAIL age_next_rob got=%0d exp=8", iss_rob[6:0]); end
    step();
  endtask

  task automatic test_hold();
    do_reset();
    iss_ready = 2'b00;
    set_enq(0, 7'd12, 7'd1, 7'd1, 2'b11);
    step();
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      peek();
      checks++; if (iss_valid !== 2'b01 || iss_rob[6:0] !== 7'd12) begin errors++; $display("FAIL hold_slot c=%0d got=%b/%0d exp=01/12", c, iss_valid, iss_rob[6:0]); end
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL hold_count c=%0d got=%0d exp=1", c, count); end
      step();
    end
    iss_ready = 2'b01;
    step();
    peek();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL hold_release got=%0d exp=0", count); end
  endtask

  task automatic test_redirect();
    do_reset();
    iss_ready = 2'b00;
    set_enq(0, 7'd60, 7'd1, 7'd1, 2'b11);
    set_enq(1, 7'd62, 7'd1, 7'd1, 2'b11);
    step(); clear_inputs();
    set_enq(0, 7'd65, 7'd1, 7'd1, 2'b11);
    step(); clear_inputs();
    iss_ready = 2'b11;
    redirect = 1'b1;
    redirect_rob = 7'd61;
    set_enq(0, 7'd20, 7'd1, 7'd1, 2'b11);
    peek();
    checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL redir_iss_valid got=%b exp=00", iss_valid); end
    step();
    clear_inputs();
    peek();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL redir_count got=%0d exp=1", count); end
    checks++; if (iss_valid !== 2'b01 || iss_rob[6:0] !== 7'd60) begin errors++; $display("FAIL redir_survivor got=%b/%0d exp=01/60", iss_valid, iss_rob[6:0]); end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      if (m_q.size() <= 14) begin
        for (int p = 0; p < 2; p++)
          if ($urandom_range(0, 1) == 1)
            set_enq(p, 7'($urandom), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)), 2'($urandom));
      end
      wb_en = 4'($urandom & $urandom);
      for (int j = 0; j < 4; j++) wb_rd[j*7 +: 7] = 7'($urandom_range(0, 15));
      iss_ready = 2'($urandom);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_rob = 7'($urandom);
      peek();
      checks++; if (iss_valid !== exp_valid) begin errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, iss_valid, exp_valid); end
      for (int k = 0; k < 2; k++) begin
        if (exp_valid[k]) begin
          checks++;
          if (iss_rob[k*7 +: 7] !== exp_rob[k] || iss_data[k*64 +: 64] !== exp_data[k] || iss_src[k*14 +: 14] !== exp_src[k]) begin
            errors++;
            $display("FAIL rand_slot%0d c=%0d got rob=%0d data=%h exp rob=%0d data=%h", k, c, iss_rob[k*7 +: 7], iss_data[k*64 +: 64], exp_rob[k], exp_data[k]);
          end
        end
      end
      checks++; if (int'(count) != m_q.size()) begin errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, m_q.size()); end
      checks++; if (enq_ready !== (m_q.size() <= 14)) begin errors++; $display("FAIL rand_enq_ready c=%0d got=%b exp=%b", c, enq_ready, m_q.size() <= 14); end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    iss_ready = 2'b00;
    clear_inputs();
    test_reset();
    test_basic();
    test_fill();
    test_wakeup();
    test_age();
    test_hold();
    test_redirect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
